// File: rtl/cacop_seq_pkg.sv
// cacop_seq_pkg: shared state, target encodings and opcode constants for the cacop sequencer
package cacop_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_ISSUE, S_WAIT, S_DONE} state_e;
  typedef enum logic [1:0] {TGT_IC = 2'd0, TGT_DC = 2'd1, TGT_L2 = 2'd2, TGT_NONE = 2'd3} tgt_e;
  localparam int IBAR_BIT = 31;
endpackage

// File: rtl/cacop_seq_if.sv
// cacop_seq_if: watchdog control bundle between the sequencer FSM and its timeout counter
interface cacop_seq_if;
  logic clr;
  logic en;
  logic expired;
  modport master (output clr, en, input expired);
  modport slave  (input clr, en, output expired);
endinterface

// File: rtl/cacop_watchdog.sv
// cacop_watchdog: cycle counter that flags expiry once it has counted TIMEOUT enabled cycles
module cacop_watchdog #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input logic        clk,
  input logic        rst,
  cacop_seq_if.slave wd
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = wd.clr ? '0 : wd.en ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign wd.expired = wd.en && (cnt_q == CNT_W'(TIMEOUT));
endmodule

// File: rtl/cacop_seq.sv
// cacop_seq: sequences cacop/ibar requests to the icache, dcache or L2, stalling the pipeline
// until the target completes or the watchdog expires.
module cacop_seq
  import cacop_seq_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_opcode,
  input  logic [31:0] req_addr,
  input  logic        req_icache,
  input  logic        req_dcache,
  input  logic        req_l2cache,
  input  logic        flush,
  input  logic        dcache_wbuf_empty,
  input  logic        ic_ready,
  input  logic        dc_ready,
  input  logic        l2_ready,
  input  logic        ic_done,
  input  logic        dc_done,
  input  logic        l2_done,
  output logic        ic_valid,
  output logic        dc_valid,
  output logic        l2_valid,
  output logic [31:0] op_addr,
  output logic [31:0] op_code,
  output logic        pipe_stall,
  output logic        op_done,
  output logic        op_err
);
  state_e      state_q, state_d;
  tgt_e        tgt_q, tgt_d;
  logic [31:0] addr_q, addr_d, code_q, code_d;
  logic        err_q, err_d;
  logic        accept, ibar, onehot, sel_ready, sel_done, busy;
  cacop_seq_if wd_if ();
  cacop_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wd (.clk(clk), .rst(rst), .wd(wd_if));
  assign accept = req_valid && !flush;
  assign ibar   = req_opcode[IBAR_BIT];
  assign onehot = (req_icache ^ req_dcache ^ req_l2cache) && !(req_icache && req_dcache && req_l2cache);
  assign sel_ready = tgt_q == TGT_IC ? ic_ready : tgt_q == TGT_DC ? dc_ready : tgt_q == TGT_L2 ? l2_ready : 1'b0;
  assign sel_done  = tgt_q == TGT_IC ? ic_done  : tgt_q == TGT_DC ? dc_done  : tgt_q == TGT_L2 ? l2_done  : 1'b0;
  assign busy = state_q == S_DRAIN || state_q == S_ISSUE || state_q == S_WAIT;
  // Counter is held clear outside DRAIN/WAIT, so it starts at zero on every entry.
  assign wd_if.en  = state_q == S_DRAIN || state_q == S_WAIT;
  assign wd_if.clr = !wd_if.en;
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    code_d  = code_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        addr_d  = req_addr;
        code_d  = req_opcode;
        tgt_d   = ibar ? TGT_IC : !onehot ? TGT_NONE : req_icache ? TGT_IC : req_dcache ? TGT_DC : TGT_L2;
        state_d = ibar ? S_DRAIN : onehot ? S_ISSUE : S_DONE;
      end
      S_DRAIN: begin
        state_d = flush ? S_IDLE : dcache_wbuf_empty ? S_ISSUE : wd_if.expired ? S_DONE : S_DRAIN;
        err_d   = !flush && !dcache_wbuf_empty && wd_if.expired;
      end
      S_ISSUE: if (sel_ready) state_d = sel_done ? S_DONE : S_WAIT;
      S_WAIT: begin
        state_d = (sel_done || wd_if.expired) ? S_DONE : S_WAIT;
        err_d   = !sel_done && wd_if.expired;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tgt_q   <= TGT_NONE;
      addr_q  <= '0;
      code_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end
  assign ic_valid   = state_q == S_ISSUE && tgt_q == TGT_IC;
  assign dc_valid   = state_q == S_ISSUE && tgt_q == TGT_DC;
  assign l2_valid   = state_q == S_ISSUE && tgt_q == TGT_L2;
  assign op_addr    = addr_q;
  assign op_code    = code_q;
  assign pipe_stall = !rst && (busy || (state_q == S_IDLE && accept));
  assign op_done    = state_q == S_DONE;
  assign op_err     = op_done && err_q;
endmodule

// File: tb/tb_cacop_seq.sv
// tb_cacop_seq: scripted cycle-by-cycle stimulus with a queue of expected output vectors
// {ic_valid, dc_valid, l2_valid, pipe_stall, op_done, op_err} popped on each falling edge.
module tb_cacop_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid, req_icache, req_dcache, req_l2cache, flush, dcache_wbuf_empty;
  logic [31:0] req_opcode, req_addr, op_addr, op_code;
  logic ic_ready, dc_ready, l2_ready, ic_done, dc_done, l2_done;
  logic ic_valid, dc_valid, l2_valid, pipe_stall, op_done, op_err;
  logic [5:0] outs;
  typedef struct {string tag; logic [5:0] exp;} ent_t;
  ent_t sb[$];
  ent_t cur;
  int n_vec = 0, n_bad = 0;
  localparam logic [5:0] IDL = 6'b000000, STL = 6'b000100, DN = 6'b000010, ER = 6'b000011;
  localparam logic [5:0] ICV = 6'b100100, DCV = 6'b010100, L2V = 6'b001100;
  localparam logic [31:0] IBAR = 32'h8000_0000;
  always #5 clk = ~clk;
  cacop_seq #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_opcode(req_opcode), .req_addr(req_addr),
    .req_icache(req_icache), .req_dcache(req_dcache), .req_l2cache(req_l2cache), .flush(flush),
    .dcache_wbuf_empty(dcache_wbuf_empty), .ic_ready(ic_ready), .dc_ready(dc_ready), .l2_ready(l2_ready),
    .ic_done(ic_done), .dc_done(dc_done), .l2_done(l2_done), .ic_valid(ic_valid), .dc_valid(dc_valid),
    .l2_valid(l2_valid), .op_addr(op_addr), .op_code(op_code), .pipe_stall(pipe_stall),
    .op_done(op_done), .op_err(op_err)
  );
  cacop_seq_if wd_if ();
  cacop_watchdog #(.TIMEOUT(3), .CNT_W(2)) u_wd (.clk(clk), .rst(rst), .wd(wd_if));
  assign outs = {ic_valid, dc_valid, l2_valid, pipe_stall, op_done, op_err};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (sb.size() != 0) begin
    cur = sb.pop_front();
    check(cur.tag, 32'(outs), 32'(cur.exp));
  end
  task automatic cyc(input string tag, input logic [5:0] e);
    sb.push_back('{tag, e});
    @(posedge clk);
    #1;
  endtask
  task automatic clr_in;
    req_valid = 0; req_opcode = 0; req_addr = 0; req_icache = 0; req_dcache = 0; req_l2cache = 0;
    flush = 0; dcache_wbuf_empty = 1;
    ic_ready = 0; dc_ready = 0; l2_ready = 0; ic_done = 0; dc_done = 0; l2_done = 0;
  endtask
  task automatic req(input logic [31:0] op, input logic [31:0] a, input logic [2:0] f);
    clr_in;
    req_valid = 1; req_opcode = op; req_addr = a;
    {req_icache, req_dcache, req_l2cache} = f;
  endtask
  initial begin
    clr_in;
    wd_if.clr = 1; wd_if.en = 0;
    @(posedge clk); #1;
    check("rst_addr", op_addr, 0);
    cyc("reset", IDL);
    rst = 0;
    // dcache op with late done; unselected ready/done toggled meanwhile
    req(32'h11, 32'h1C00_0040, 3'b010); cyc("dc_c0", STL);
    clr_in; dc_ready = 1; ic_done = 1; l2_ready = 1; cyc("dc_c1", DCV);
    clr_in; ic_done = 1; l2_done = 1;
    check("dc_addr", op_addr, 32'h1C00_0040); check("dc_code", op_code, 32'h11);
    cyc("dc_c2", STL);
    clr_in; dc_done = 1; cyc("dc_c3", STL);
    clr_in; cyc("dc_c4", DN);
    cyc("dc_c5", IDL);
    // minimum latency through L2
    req(32'h22, 32'h100, 3'b001); cyc("l2min_c0", STL);
    clr_in; l2_ready = 1; l2_done = 1; cyc("l2min_c1", L2V);
    clr_in; cyc("l2min_c2", DN); cyc("l2min_c3", IDL);
    // ibar waits for write buffer drain
    req(IBAR, 32'h200, 3'b000); dcache_wbuf_empty = 0; cyc("ib_c0", STL);
    for (int i = 1; i < 5; i++) begin clr_in; dcache_wbuf_empty = 0; cyc("ib_drain", STL); end
    clr_in; cyc("ib_empty", STL);
    clr_in; ic_ready = 1; check("ib_code", op_code, IBAR); cyc("ib_issue", ICV);
    clr_in; ic_done = 1; cyc("ib_wait", STL);
    req(32'h33, 32'h300, 3'b010); cyc("ib_done_req", DN);
    clr_in; cyc("ib_idle", IDL);
    check("ib_keep_code", op_code, IBAR);
    // flush during drain aborts
    req(IBAR, 32'h210, 3'b000); dcache_wbuf_empty = 0; cyc("fl_c0", STL);
    clr_in; dcache_wbuf_empty = 0; flush = 1; cyc("fl_drain", STL);
    clr_in; cyc("fl_idle", IDL); cyc("fl_idle2", IDL);
    // request with flush in IDLE is dropped
    req(32'h44, 32'h400, 3'b010); flush = 1; cyc("flreq_c0", IDL);
    clr_in; dc_ready = 1; cyc("flreq_c1", IDL);
    // no target and multiple targets go straight to DONE
    req(32'h5, 32'h500, 3'b000); cyc("nt_c0", STL);
    clr_in; cyc("nt_c1", DN); cyc("nt_c2", IDL);
    req(32'h6, 32'h600, 3'b011); cyc("mt_c0", STL);
    clr_in; dc_ready = 1; l2_ready = 1; cyc("mt_c1", DN); cyc("mt_c2", IDL);
    // WAIT timeout
    req(32'h7, 32'h700, 3'b001); cyc("to_c0", STL);
    clr_in; l2_ready = 1; cyc("to_c1", L2V);
    clr_in;
    for (int i = 0; i < 9; i++) cyc("to_wait", STL);
    cyc("to_done", ER); cyc("to_idle", IDL);
    // done on the expiry cycle beats the timeout
    req(32'h8, 32'h800, 3'b001); cyc("tie_c0", STL);
    clr_in; l2_ready = 1; cyc("tie_c1", L2V);
    clr_in;
    for (int i = 0; i < 8; i++) cyc("tie_wait", STL);
    l2_done = 1; cyc("tie_last", STL);
    clr_in; cyc("tie_done", DN); cyc("tie_idle", IDL);
    // DRAIN timeout
    req(IBAR, 32'h900, 3'b000); dcache_wbuf_empty = 0; cyc("dto_c0", STL);
    for (int i = 0; i < 9; i++) begin clr_in; dcache_wbuf_empty = 0; cyc("dto_drain", STL); end
    clr_in; dcache_wbuf_empty = 0; cyc("dto_done", ER);
    clr_in; cyc("dto_idle", IDL);
    // reset while in WAIT, then a fresh request
    req(32'h9, 32'hA00, 3'b010); cyc("rw_c0", STL);
    clr_in; dc_ready = 1; cyc("rw_c1", DCV);
    clr_in; cyc("rw_wait", STL);
    rst = 1; #1;
    check("rw_addr", op_addr, 0); check("rw_code", op_code, 0);
    cyc("rw_rst", IDL);
    rst = 0; dc_done = 1; cyc("rw_after", IDL);
    req(32'hB, 32'hB00, 3'b001); cyc("rw_new_c0", STL);
    clr_in; l2_ready = 1; l2_done = 1; cyc("rw_new_c1", L2V);
    clr_in; cyc("rw_new_c2", DN); cyc("rw_new_c3", IDL);
    // standalone watchdog
    wd_if.clr = 0; wd_if.en = 1;
    for (int k = 0; k < 4; k++) begin
      check("wd_exp", 32'(wd_if.expired), 32'(k == 3));
      @(posedge clk); #1;
    end
    wd_if.clr = 1; wd_if.en = 0;
    @(posedge clk); #1;
    check("wd_clr", 32'(wd_if.expired), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
